// File: rtl/iobuf_dir_ctrl.sv
// Direction/turnaround controller for an FPGA pad + 74LVC1T45 level shifter + 74LVC1G07 open-drain buffer.
// Every mode change walks RELEASE -> DIRSET -> APPLY so that no two drivers ever fight on the pin.
module iobuf_dir_ctrl #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    output logic       mode_ready,
    output logic       mode_done,
    output logic [1:0] mode_cur,
    output logic       busy,
    input  logic       dout,
    output logic       din,
    input  logic       bufio_in,
    output logic       fpga_oe,
    output logic       fpga_do,
    output logic       bufdir,
    output logic       bufod,
    output logic       contention
);

    localparam logic [1:0] MODE_HIZ = 2'b00;
    localparam logic [1:0] MODE_PP  = 2'b10;
    localparam logic [1:0] MODE_OD  = 2'b11;
    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {STABLE, RELEASE, DIRSET, APPLY} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] tgt_q, tgt_d;
    logic [1:0] mode_cur_q, mode_cur_d;
    logic       mode_ready_q, mode_ready_d;
    logic       mode_done_q, mode_done_d;
    logic       busy_q, busy_d;
    logic       bufdir_q, bufdir_d;
    logic       bufod_q, bufod_d;
    logic       fpga_oe_q, fpga_oe_d;
    logic       fpga_do_q, fpga_do_d;
    logic       sync_q, sync_d;
    logic       din_q, din_d;
    logic       contention_q, contention_d;
    logic       accept;
    logic [1:0] drv_mode;

    assign accept = mode_valid & mode_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        mode_cur_d  = mode_cur_q;
        mode_done_d = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (accept) begin
                    if (mode_req == mode_cur_q) begin
                        mode_done_d = 1'b1;
                    end else begin
                        tgt_d   = mode_req;
                        cnt_d   = CNT_RELOAD;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (cnt_q == 8'd0) begin
                    state_d = DIRSET;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DIRSET: begin
                if (cnt_q == 8'd0) state_d = APPLY;
                else               cnt_d   = cnt_q - 8'd1;
            end
            APPLY: begin
                state_d     = STABLE;
                mode_cur_d  = tgt_q;
                mode_done_d = 1'b1;
            end
            default: state_d = STABLE;
        endcase
        // ready/busy look at the next state so a request is refused the cycle right after acceptance
        mode_ready_d = (state_d == STABLE);
        busy_d       = ~mode_ready_d;
    end

    // Pad drivers: bufdir only ever moves in DIRSET; everything else is safe-off during turnaround.
    always_comb begin
        drv_mode  = (state_q == APPLY) ? tgt_q : mode_cur_q;
        bufdir_d  = bufdir_q;
        bufod_d   = 1'b1;
        fpga_oe_d = 1'b0;
        fpga_do_d = 1'b0;
        unique case (state_q)
            STABLE, APPLY: begin
                if (drv_mode == MODE_PP) begin
                    fpga_oe_d = 1'b1;
                    fpga_do_d = dout;
                end else if (drv_mode == MODE_OD) begin
                    bufod_d = dout;
                end
            end
            DIRSET:  bufdir_d = (tgt_q == MODE_PP);
            default: ;
        endcase
    end

    // Readback synchronizer runs in modes 01/11 (bit0 set) and restarts from zero on mode entry.
    always_comb begin
        sync_d = 1'b0;
        din_d  = 1'b0;
        if (state_q != APPLY && mode_cur_q[0]) begin
            sync_d = bufio_in;
            din_d  = sync_q;
        end
        contention_d = contention_q | (fpga_oe_q & ~bufdir_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= STABLE;
            cnt_q        <= 8'd0;
            tgt_q        <= MODE_HIZ;
            mode_cur_q   <= MODE_HIZ;
            mode_ready_q <= 1'b1;
            mode_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            bufdir_q     <= 1'b0;
            bufod_q      <= 1'b1;
            fpga_oe_q    <= 1'b0;
            fpga_do_q    <= 1'b0;
            sync_q       <= 1'b0;
            din_q        <= 1'b0;
            contention_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tgt_q        <= tgt_d;
            mode_cur_q   <= mode_cur_d;
            mode_ready_q <= mode_ready_d;
            mode_done_q  <= mode_done_d;
            busy_q       <= busy_d;
            bufdir_q     <= bufdir_d;
            bufod_q      <= bufod_d;
            fpga_oe_q    <= fpga_oe_d;
            fpga_do_q    <= fpga_do_d;
            sync_q       <= sync_d;
            din_q        <= din_d;
            contention_q <= contention_d;
        end
    end

    assign mode_ready = mode_ready_q;
    assign mode_done  = mode_done_q;
    assign mode_cur   = mode_cur_q;
    assign busy       = busy_q;
    assign din        = din_q;
    assign fpga_oe    = fpga_oe_q;
    assign fpga_do    = fpga_do_q;
    assign bufdir     = bufdir_q;
    assign bufod      = bufod_q;
    assign contention = contention_q;

endmodule

// File: tb/tb_iobuf_dir_ctrl.sv
// Bench for iobuf_dir_ctrl: directed turnaround sequences, a steady-state driver table,
// and random traffic compared every cycle against a timeline model.
module tb_iobuf_dir_ctrl;

    localparam int S = 4;
    localparam logic [10:0] RST_VEC = 11'b1_0_0_00_0_1_0_0_0_0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode_req = 2'b00;
    logic       mode_valid = 1'b0;
    logic       mode_ready, mode_done, busy;
    logic [1:0] mode_cur;
    logic       dout = 1'b0;
    logic       din;
    logic       bufio_in = 1'b0;
    logic       fpga_oe, fpga_do, bufdir, bufod, contention;

    iobuf_dir_ctrl #(.SETTLE(S)) dut (
        .clock(clock), .reset(reset), .mode_req(mode_req), .mode_valid(mode_valid),
        .mode_ready(mode_ready), .mode_done(mode_done), .mode_cur(mode_cur), .busy(busy),
        .dout(dout), .din(din), .bufio_in(bufio_in), .fpga_oe(fpga_oe), .fpga_do(fpga_do),
        .bufdir(bufdir), .bufod(bufod), .contention(contention)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [10:0] dut_vec, exp_vec;
    assign dut_vec = {mode_ready, busy, mode_done, mode_cur, bufdir, bufod, fpga_oe, fpga_do, din, contention};

    // Reference model: counts edges since the accepting edge and derives the phase from that
    // count (1..S release, S+1..2S direction set, 2S+1 apply).
    int         acc_k, in_cnt;
    logic [1:0] e_cur, e_tgt;
    logic       e_done, e_bufdir, e_od, e_oe, e_do, e_din, h0, h1;

    task automatic m_vec();
        exp_vec = {acc_k < 0, acc_k >= 0, e_done, e_cur, e_bufdir, e_od, e_oe, e_do, e_din, 1'b0};
    endtask

    task automatic m_init();
        acc_k = -1; in_cnt = 0; e_cur = 2'b00; e_tgt = 2'b00; e_done = 0;
        e_bufdir = 0; e_od = 1; e_oe = 0; e_do = 0; e_din = 0; h0 = 0; h1 = 0;
        m_vec();
    endtask

    task automatic m_step();
        int ph;  // 0 steady, 1 release, 2 dirset, 3 apply
        ph = 0;
        e_done = 0;
        if (acc_k >= 0) begin
            acc_k++;
            if (acc_k <= S) ph = 1;
            else if (acc_k <= 2 * S) ph = 2;
            else begin ph = 3; e_cur = e_tgt; e_done = 1; acc_k = -1; end
        end else if (mode_valid) begin
            if (mode_req == e_cur) e_done = 1;
            else begin e_tgt = mode_req; acc_k = 0; end
        end
        e_oe = 0; e_do = 0; e_od = 1;
        if (ph == 0 || ph == 3) begin
            e_oe = (e_cur == 2'b10);
            e_do = (e_cur == 2'b10) && dout;
            e_od = (e_cur == 2'b11) ? dout : 1'b1;
        end
        if (ph == 2) e_bufdir = (e_tgt == 2'b10);
        h1 = h0; h0 = bufio_in;
        if (ph == 3) in_cnt = 0;
        else if (in_cnt < 2) in_cnt++;
        e_din = ((e_cur == 2'b01 || e_cur == 2'b11) && in_cnt >= 2) ? h1 : 1'b0;
        m_vec();
    endtask

    initial begin
        m_init();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) m_init();
            else m_step();
        end
    end

    always @(negedge clock) chk("model", 16'(dut_vec), 16'(exp_vec));

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic req(input logic [1:0] m);
        mode_req = m; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       d;
        logic [3:0] exp;  // {bufdir, bufod, fpga_oe, fpga_do}
    } vec_t;
    vec_t tbl[8];
    logic       rb;
    logic [2:0] bits;

    initial begin
        tbl[0] = '{2'b00, 1'b0, 4'b0100}; tbl[1] = '{2'b00, 1'b1, 4'b0100};
        tbl[2] = '{2'b01, 1'b0, 4'b0100}; tbl[3] = '{2'b01, 1'b1, 4'b0100};
        tbl[4] = '{2'b10, 1'b0, 4'b1110}; tbl[5] = '{2'b10, 1'b1, 4'b1111};
        tbl[6] = '{2'b11, 1'b0, 4'b0000}; tbl[7] = '{2'b11, 1'b1, 4'b0100};

        // reset, then idle
        repeat (3) tick();
        chk("reset_vals", 16'(dut_vec), 16'(RST_VEC));
        reset = 1'b0;
        repeat (10) tick();
        chk("idle", 16'({mode_cur, bufdir, bufod, fpga_oe, mode_ready, contention}), 16'(7'b00_0_1_0_1_0));

        // 00 -> 10
        dout = 1'b1;
        req(2'b10);
        for (int k = 1; k <= 2 * S + 1; k++) begin
            tick();
            chk("pp_oe", 16'(fpga_oe), 16'(k == 2 * S + 1));
            chk("pp_dir", 16'(bufdir), 16'(k > S));
            chk("pp_done", 16'(mode_done), 16'(k == 2 * S + 1));
        end
        for (int i = 0; i < 6; i++) begin
            rb = 1'($urandom);
            dout = rb;
            tick();
            chk("pp_do", 16'(fpga_do), 16'(rb));
        end

        // 10 -> 01 with readback
        bufio_in = 1'b1;
        req(2'b01);
        for (int k = 1; k <= 2 * S + 3; k++) begin
            tick();
            if (k <= 2 * S + 1) begin
                chk("in_oe", 16'(fpga_oe), 16'd0);
                chk("in_dir", 16'(bufdir), 16'(k <= S));
                chk("in_done", 16'(mode_done), 16'(k == 2 * S + 1));
            end
        end
        chk("in_din", 16'(din), 16'd1);
        chk("in_cont", 16'(contention), 16'd0);

        // 01 -> 11, dout 1,0,1
        req(2'b11);
        repeat (2 * S + 1) tick();
        bits = 3'b101;
        for (int i = 0; i < 3; i++) begin
            dout = bits[2 - i];
            tick();
            chk("od_bufod", 16'(bufod), 16'(bits[2 - i]));
            chk("od_oe_dir", 16'({fpga_oe, bufdir}), 16'd0);
        end

        // same-mode request, then a request during busy
        req(2'b01);
        repeat (2 * S + 1) tick();
        req(2'b01);
        chk("same_done", 16'({mode_done, busy}), 16'(2'b10));
        tick();
        chk("same_after", 16'({mode_done, busy}), 16'(2'b00));
        req(2'b00);
        tick();
        mode_req = 2'b10; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        repeat (2 * S - 1) tick();
        chk("ign_done", 16'({mode_done, mode_cur}), 16'(3'b1_00));
        for (int k = 0; k < 2 * S + 4; k++) begin
            tick();
            chk("ign_hold", 16'({mode_done, busy, mode_cur}), 16'(4'b0_0_00));
        end

        // reset during DIRSET of 00 -> 10
        req(2'b10);
        repeat (S + 2) tick();
        chk("pre_rst_dir", 16'(bufdir), 16'd1);
        #2 reset = 1'b1;
        #1 chk("rst_async", 16'(dut_vec), 16'(RST_VEC));
        tick(); tick();
        chk("rst_hold", 16'(dut_vec), 16'(RST_VEC));
        reset = 1'b0;
        req(2'b10);
        for (int k = 1; k <= 2 * S + 1; k++) begin
            tick();
            chk("rst_lat", 16'(mode_done), 16'(k == 2 * S + 1));
        end

        // steady-state driver table
        for (int i = 0; i < 8; i++) begin
            req(tbl[i].mode);
            repeat (2 * S + 1) tick();
            dout = tbl[i].d;
            tick();
            chk($sformatf("tbl%0d", i), 16'({bufdir, bufod, fpga_oe, fpga_do}), 16'(tbl[i].exp));
        end

        // random traffic, including occasional asynchronous reset pulses
        for (int c = 0; c < 1500; c++) begin
            mode_valid = ($urandom_range(3) == 0);
            mode_req   = 2'($urandom);
            dout       = 1'($urandom);
            bufio_in   = 1'($urandom);
            if ($urandom_range(299) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end
        mode_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iobuf_dir_ctrl.md
IOBUF_DIR_CTRL -- requirements
Module: iobuf_dir_ctrl

Interface
REQ-001 The parameter SETTLE SHALL be defined as: SETTLE, default 4, settle cycles per turnaround phase; legal range 1..255.
REQ-002 The port list SHALL be exactly the following, one port per line, in this order (name, direction, width, meaning).
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode_req  in  2  requested mode: 00 HiZ, 01 input, 10 push-pull out, 11 open-drain out.
- mode_valid  in  1  request strobe.
- mode_ready  out  1  controller can accept a request.
- mode_done  out  1  one-cycle pulse when the requested mode is in effect.
- mode_cur  out  2  mode currently in effect.
- busy  out  1  turnaround in progress.
- dout  in  1  data to drive in the output modes.
- din  out  1  synchronized pin readback.
- bufio_in  in  1  FPGA pad input path.
- fpga_oe  out  1  FPGA pad tristate enable; 1 means the FPGA drives.
- fpga_do  out  1  FPGA pad output data.
- bufdir  out  1  74LVC1T45 DIR; 0 means pin-to-FPGA direction, with the header side HiZ.
- bufod  out  1  74LVC1G07 input; 1 means HiZ, 0 means GND.
- contention  out  1  sticky fault flag.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have exactly the states STABLE, RELEASE, DIRSET and APPLY.
REQ-005 mode_ready SHALL be 1 only in STABLE.
REQ-006 busy SHALL equal NOT mode_ready.
REQ-007 A request SHALL be accepted on any edge where mode_valid=1 and mode_ready=1.
REQ-008 While mode_ready=0, requests SHALL be ignored and SHALL NOT be queued.
REQ-009 On accepting a mode_req equal to mode_cur, the FSM SHALL stay in STABLE, leave the outputs unchanged, and pulse mode_done on the next cycle.
REQ-010 On accepting a different mode, the block SHALL latch the target mode and enter RELEASE.
REQ-011 In RELEASE, fpga_oe=0 and bufod=1, with bufdir held.
REQ-012 RELEASE SHALL last SETTLE cycles and then advance to DIRSET.
REQ-013 In DIRSET, bufdir SHALL be set to the target value: 1 for push-pull, 0 otherwise.
REQ-014 In DIRSET, fpga_oe=0 and bufod=1.
REQ-015 DIRSET SHALL last SETTLE cycles and then advance to APPLY.
REQ-016 APPLY SHALL last 1 cycle, during which the target drivers are enabled.
REQ-017 In APPLY, mode_cur SHALL be set to the target, mode_done SHALL pulse, and the next state SHALL be STABLE.
REQ-018 Latency: mode_done SHALL be high exactly 2*SETTLE+1 cycles after the accepting edge.
REQ-019 Steady-state driver values for HiZ (00) and input (01) SHALL be: bufdir=0, bufod=1, fpga_oe=0.
REQ-020 Steady-state driver values for push-pull (10) SHALL be: bufdir=1, bufod=1, fpga_oe=1, fpga_do=dout registered (1-cycle latency).
REQ-021 Steady-state driver values for open-drain (11) SHALL be: bufdir=0, fpga_oe=0, bufod=dout registered (1-cycle latency); dout=1 means HiZ.
REQ-022 fpga_do SHALL be 0 whenever fpga_oe=0.
REQ-023 din SHALL be a 2-flop synchronizer of bufio_in that updates only in modes 01 and 11.
REQ-024 In modes 00 and 10, din SHALL hold 0.
REQ-025 On entering mode 01 or 11, the synchronizer SHALL be cleared and din SHALL be valid 2 cycles later.
REQ-026 Invariant: fpga_oe=1 with bufdir=0 SHALL never occur.
REQ-027 Invariant: bufod=0 with fpga_oe=1 SHALL never occur.
REQ-028 Invariant: bufdir SHALL change only in DIRSET.
REQ-029 contention SHALL be set on any cycle where registered fpga_oe=1 and bufdir=0.
REQ-030 contention SHALL be cleared only by reset.
REQ-031 The phase counter SHALL be 8 bits wide and SHALL reload SETTLE-1 on each phase entry.
REQ-032 The phase counter SHALL advance the state at zero, with no wrap.
REQ-033 A dout change during a turnaround SHALL be absorbed, and APPLY SHALL use the dout registered in that cycle.

Reset
REQ-034 While reset=1, the outputs SHALL immediately take their reset values: state STABLE, mode_cur=00, mode_ready=1, busy=0, mode_done=0, bufdir=0, bufod=1, fpga_oe=0, fpga_do=0, din=0, contention=0, counter=0, synchronizer=0.
REQ-035 Reset asserted mid-turnaround SHALL abort it, with no mode_done pulse.
REQ-036 After reset releases, the first accepting edge SHALL be the next rising clock edge.

Verification
REQ-037 The bench SHALL cover: reset, then idle 10 cycles -> mode_cur=00, bufdir=0, bufod=1, fpga_oe=0, mode_ready=1, contention=0.
REQ-038 The bench SHALL cover: SETTLE=4, request 10 at cycle 0 -> fpga_oe=0 for cycles 1-8, bufdir rises at cycle 5, fpga_oe=1 and mode_done=1 at cycle 9, fpga_do tracks dout with 1 cycle delay.
REQ-039 The bench SHALL cover: from 10, request 01 -> fpga_oe falls at cycle 1, bufdir falls at cycle 5, mode_done at cycle 9; with bufio_in=1, din=1 by cycle 11; contention stays 0 throughout.
REQ-040 The bench SHALL cover: mode 11 with dout toggling 1,0,1 -> bufod follows 1,0,1 delayed 1 cycle, fpga_oe=0 and bufdir=0 constant.
REQ-041 The bench SHALL cover: request 01 while in 01 -> mode_done at the next cycle, busy stays 0; a new request during busy -> ignored, and mode_cur ends at the first target.
REQ-042 The bench SHALL cover: reset asserted during DIRSET of a 00->10 change -> immediate reset values, no mode_done, and a later 10 request completes in 2*SETTLE+1 cycles.
